// File: rtl/fib_seq_ctrl_if.sv
// Term stream between the Fibonacci sequencer (master) and its consumer (slave).
interface fib_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
);
    logic [WIDTH-1:0] fib_out;
    logic             fib_valid;
    logic             fib_ready;
    logic [CNT_W-1:0] term_idx;

    modport master (
        output fib_out,
        output fib_valid,
        output term_idx,
        input  fib_ready
    );

    modport slave (
        input  fib_out,
        input  fib_valid,
        input  term_idx,
        output fib_ready
    );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencing stage: holds the last two terms, advances them through an
// external adder and streams F(0), F(1), ... until the count or a carry-out ends it.
module fib_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    fib_seq_ctrl_if.master   strm,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_a_q, r_a_d;
    logic [WIDTH-1:0] r_b_q, r_b_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_lat_q, n_lat_d;
    logic             ovf_pending_q, ovf_pending_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic handshake;
    logic last_term;

    assign handshake = valid_q && strm.fib_ready;
    assign last_term = (idx_q == n_lat_q - 1'b1);

    always_comb begin
        state_d       = state_q;
        r_a_d         = r_a_q;
        r_b_d         = r_b_q;
        idx_d         = idx_q;
        n_lat_d       = n_lat_q;
        ovf_pending_d = ovf_pending_q;
        overflow_d    = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    overflow_d = 1'b0;
                    if (num_terms != '0) begin
                        r_a_d         = '0;
                        r_b_d         = WIDTH'(1);
                        idx_d         = '0;
                        n_lat_d       = num_terms;
                        ovf_pending_d = 1'b0;
                        state_d       = EMIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (last_term) begin
                        state_d = DONE;
                    end else if (ovf_pending_q) begin
                        // r_b carries a wrapped sum, so the next term would be wrong.
                        overflow_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        r_a_d         = r_b_q;
                        r_b_d         = add_sum;
                        idx_d         = idx_q + 1'b1;
                        ovf_pending_d = add_cout;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == EMIT);
        busy_d  = (state_d == EMIT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            r_a_q         <= '0;
            r_b_q         <= '0;
            idx_q         <= '0;
            n_lat_q       <= '0;
            ovf_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_a_q         <= r_a_d;
            r_b_q         <= r_b_d;
            idx_q         <= idx_d;
            n_lat_q       <= n_lat_d;
            ovf_pending_q <= ovf_pending_d;
            overflow_q    <= overflow_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign add_a          = r_a_q;
    assign add_b          = r_b_q;
    assign strm.fib_out   = r_a_q;
    assign strm.fib_valid = valid_q;
    assign strm.term_idx  = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: directed scenarios plus randomized runs
// compared against an integer Fibonacci reference model.
module tb_fib_seq_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_terms;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cout;
    logic             busy, done, overflow;

    fib_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) strm_if ();

    fib_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_terms (num_terms),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .strm      (strm_if),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // Behavioural 4-bit adder standing in for the external ripple-carry instance.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int nxt_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // True Fibonacci values; a term is emitted only while it fits in WIDTH bits.
    task automatic build_model(input int n, output int cnt, output int ovf);
        int f0 = 0;
        int f1 = 1;
        int t;
        exp_q.delete();
        nxt_q.delete();
        while (exp_q.size() < n && f0 < (1 << WIDTH)) begin
            exp_q.push_back(f0);
            nxt_q.push_back(f1 % (1 << WIDTH));
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
        end
        cnt = exp_q.size();
        ovf = (cnt < n) ? 1 : 0;
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: 0,0,1,0,1,...
    task automatic run_seq(input int n, input int mode, input bit glitch);
        int  cnt, ovf, k, cyc;
        bit  fin, rdy;
        build_model(n, cnt, ovf);
        k   = 0;
        fin = 0;
        @(negedge clk);
        start     = 1'b1;
        num_terms = CNT_W'(n);
        strm_if.fib_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 400 && !fin; cyc++) begin
            start = 1'b0;
            if (done) begin
                fin = 1;
            end else if (strm_if.fib_valid) begin
                if (k >= cnt) begin
                    check("extra_term", k, cnt - 1);
                    fin = 1;
                end else begin
                    check("fib_out", int'(strm_if.fib_out), exp_q[k]);
                    check("term_idx", int'(strm_if.term_idx), k);
                    check("add_b", int'(add_b), nxt_q[k]);
                    check("busy", int'(busy), 1);
                    case (mode)
                        0:       rdy = 1'b1;
                        1:       rdy = 1'($urandom_range(0, 1));
                        default: rdy = (cyc >= 2) && (cyc % 2 == 0);
                    endcase
                    if (glitch && k == 2) begin
                        start     = 1'b1;
                        num_terms = CNT_W'(2);
                    end
                    strm_if.fib_ready = rdy;
                    if (rdy) k++;
                    @(negedge clk);
                end
            end else begin
                check("valid_or_done", 0, 1);
                fin = 1;
            end
        end
        start = 1'b0;
        strm_if.fib_ready = 1'b0;
        check("done_seen", int'(fin), 1);
        check("term_count", k, cnt);
        check("overflow", int'(overflow), ovf);
        check("busy_at_done", int'(busy), 0);
        $display("run n=%0d mode=%0d glitch=%0d terms=%0d overflow=%0d", n, mode, glitch, k, overflow);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_valid", int'(strm_if.fib_valid), 0);
        check("overflow_sticky", int'(overflow), ovf);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        num_terms = '0;
        strm_if.fib_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", int'(strm_if.fib_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_idx", int'(strm_if.term_idx), 0);
        check("rst_add_b", int'(add_b), 0);

        run_seq(8, 0, 1'b0);
        run_seq(10, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf_hold_idle", int'(overflow), 1);
        run_seq(5, 2, 1'b0);
        run_seq(0, 0, 1'b0);
        run_seq(1, 0, 1'b0);
        run_seq(6, 0, 1'b1);

        // Reset while term 3 is on the stream.
        @(negedge clk);
        start = 1'b1;
        num_terms = CNT_W'(8);
        strm_if.fib_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 20 && strm_if.term_idx != CNT_W'(3); cyc++) @(negedge clk);
        check("reach_idx3", int'(strm_if.term_idx), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        strm_if.fib_ready = 1'b0;
        check("midrst_valid", int'(strm_if.fib_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_idx", int'(strm_if.term_idx), 0);
        run_seq(3, 0, 1'b0);

        // Reset also clears a sticky overflow.
        run_seq(12, 1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clears_ovf", int'(overflow), 0);

        for (int i = 0; i < 14; i++) begin
            run_seq($urandom_range(0, 31), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Sequencing stage of the hierarchical Fibonacci generator.
- Holds the two most recent terms and drives them into the external 4-bit ripple-carry adder instance. Captures that adder's sum and carry-out to advance the sequence.
- Emits terms F(0), F(1), ... over a valid/ready stream.
- Detects carry-out overflow and truncates the sequence cleanly.

Parameters:
- WIDTH, 4, term width; must equal the adder operand width.
- CNT_W, 5, width of the term-count request and of the term index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sequence; sampled only in IDLE.
- num_terms  input  CNT_W  number of terms requested; latched on accepted start.
- add_a  output  WIDTH  adder operand A; driven combinationally from r_a.
- add_b  output  WIDTH  adder operand B; driven combinationally from r_b.
- add_sum  input  WIDTH  adder sum; treated as combinational, same cycle.
- add_cout  input  1  adder carry-out.
- fib_out  output  WIDTH  current term.
- fib_valid  output  1  fib_out holds a valid term.
- fib_ready  input  1  downstream accepts the term.
- term_idx  output  CNT_W  index k of the term on fib_out.
- busy  output  1  high in EMIT.
- done  output  1  one-cycle pulse when the sequence ends.
- overflow  output  1  sticky; the sequence was truncated because of carry-out.

Behaviour:
- Reset (sync, rst=1 at a clk edge), regardless of state:
  - state=IDLE; r_a=0; r_b=0; term_idx=0; n_lat=0; ovf_pending=0.
  - fib_valid=0, busy=0, done=0, overflow=0.
  - Mid-sequence reset drops the in-flight term with no handshake.
- Outputs by construction:
  - fib_out=r_a at all times.
  - add_a=r_a and add_b=r_b at all times.
  - fib_valid=1 only in EMIT.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 and num_terms!=0: r_a=0, r_b=1, term_idx=0, n_lat=num_terms, ovf_pending=0, overflow=0; go to EMIT.
  - start=1 and num_terms=0: clear overflow; go to DONE. No term is emitted.
- EMIT:
  - Hold r_a, r_b and term_idx stable while fib_valid=1 and fib_ready=0.
  - On handshake (fib_valid and fib_ready), last term (term_idx==n_lat-1): go to DONE.
  - On handshake, not last, ovf_pending=1: overflow<=1; go to DONE. The sequence is truncated.
  - On handshake, not last, ovf_pending=0: r_a<=r_b, r_b<=add_sum, term_idx<=term_idx+1, ovf_pending<=add_cout; stay in EMIT.
- DONE: done=1 for exactly one cycle; go to IDLE. overflow holds its value until the next accepted start.
- start is ignored outside IDLE, including in the DONE cycle.
- Latency:
  - First term F(0) is valid on the cycle after start.
  - With fib_ready held at 1, one term is emitted per cycle.
  - done asserts in the cycle after the final handshake.
- Overflow rule: a carry on an advance poisons only r_b. r_b is emitted only after one further advance. Because of this, a carry that occurs while the last requested term is still pending never flags overflow.
- Width rule: arithmetic is modulo 2^WIDTH, coming from the adder. term_idx does not wrap, since n_lat ≤ 2^CNT_W-1.

Test Plan:
- Basic run: rst pulse, then start with num_terms=8 and fib_ready=1.
  - Required: fib_out stream 0,1,1,2,3,5,8,13 on consecutive cycles; term_idx 0..7.
  - Required: done pulses one cycle after term 13; overflow=0.
- Truncation: num_terms=10, fib_ready=1.
  - Required: the same 8 terms are emitted.
  - Required: on the handshake of 13, overflow=1 and done pulses; no 9th term appears; overflow stays 1 in IDLE.
- Backpressure: num_terms=5, fib_ready toggling 0,0,1,0,1,....
  - Required: fib_out and term_idx hold while ready=0; stream is exactly 0,1,1,2,3; done pulses once.
- Zero/one terms:
  - num_terms=0: required done pulse one cycle after start, fib_valid never 1.
  - num_terms=1: required single term 0, then done.
- Reset mid-run: assert rst while term_idx=3.
  - Required: next cycle fib_valid=0, busy=0, overflow=0, term_idx=0.
  - Required: a new start with num_terms=3 yields 0,1,1.
- Start while busy: pulse start during EMIT of term 2 with num_terms changed to 2.
  - Required: ignored; the original sequence completes with the original count.
